// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: payload plus side-effect controls behind a valid/ready handshake.
// Supports backpressure stall, flush to a bubble, and an optional 2-entry skid that registers in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              main_free;
  logic              accept;

  assign main_free = !main_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // With a skid, in_ready depends only on registered state so out_ready never reaches it.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = !rst && !skid_valid;
    end else begin : g_noskid
      assign in_ready = !rst && main_free;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      // Payload is kept; only validity and controls are squashed.
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (SKID != 0) begin
      if (main_free) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_data  <= skid_data;
          main_ctrl  <= skid_ctrl;
          skid_valid <= 1'b0;
          skid_ctrl  <= '0;
        end else if (accept) begin
          main_valid <= 1'b1;
          main_data  <= in_data;
          main_ctrl  <= in_ctrl;
        end else begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
        skid_ctrl  <= in_ctrl;
      end
    end else begin
      if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
        main_ctrl  <= in_ctrl;
      end else if (main_free) begin
        main_valid <= 1'b0;
        main_ctrl  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table on the skid variant, streaming on both
// variants, then random valid/ready/flush traffic against per-variant FIFO scoreboards.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] out_data0, out_data1;
  logic [7:0]  out_ctrl0, out_ctrl1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_ctrl(out_ctrl0));

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_ctrl(out_ctrl1));

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [31:0] d;
    logic [7:0]  c;
    logic        fl;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [7:0]  e_oc;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  c;
  } ent_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  ent_t q0[$];
  ent_t q1[$];

  initial begin
    logic        e_ir0, e_ir1;
    logic [31:0] seq;

    // rst iv data ctrl fl ordy | in_ready(before edge) out_valid out_data out_ctrl(after edge)
    vecs[0]  = '{1'b1, 1'b1, 32'h11, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  8'h00};
    vecs[1]  = '{1'b1, 1'b1, 32'h11, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  8'h00};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  8'h00};
    vecs[3]  = '{1'b0, 1'b1, 32'hA,  8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA,  8'h0F};
    vecs[4]  = '{1'b0, 1'b1, 32'hB,  8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA,  8'h0F};
    vecs[5]  = '{1'b0, 1'b1, 32'hE,  8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA,  8'h0F};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'hB,  8'h3C};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'hB,  8'h00};
    vecs[8]  = '{1'b0, 1'b1, 32'hA1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA1, 8'hFF};
    vecs[9]  = '{1'b0, 1'b1, 32'hB1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA1, 8'hFF};
    vecs[10] = '{1'b0, 1'b1, 32'hC1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA1, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA1, 8'h00};
    vecs[12] = '{1'b0, 1'b1, 32'h21, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 32'h21, 8'h12};
    vecs[13] = '{1'b0, 1'b1, 32'h22, 8'h34, 1'b1, 1'b0, 1'b1, 1'b0, 32'h21, 8'h00};
    vecs[14] = '{1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h21, 8'h00};
    vecs[15] = '{1'b0, 1'b1, 32'h31, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 32'h31, 8'h81};
    vecs[16] = '{1'b0, 1'b0, 32'h0,  8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 32'h31, 8'h00};
    vecs[17] = '{1'b0, 1'b1, 32'h41, 8'h41, 1'b0, 1'b0, 1'b1, 1'b1, 32'h41, 8'h41};
    vecs[18] = '{1'b0, 1'b1, 32'h42, 8'h42, 1'b0, 1'b0, 1'b1, 1'b1, 32'h41, 8'h41};
    vecs[19] = '{1'b1, 1'b1, 32'h43, 8'h43, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  8'h00};
    vecs[20] = '{1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  8'h00};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].d;
      in_ctrl = vecs[i].c; flush = vecs[i].fl; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready1, vecs[i].e_ir);
      if (i == 16) chk("flush_drain_head_seen", out_valid1 && out_ready, 1'b1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), out_valid1, vecs[i].e_ov);
      chk($sformatf("v%0d_out_data", i), out_data1, vecs[i].e_od);
      chk($sformatf("v%0d_out_ctrl", i), out_ctrl1, vecs[i].e_oc);
    end

    // Streaming 1..8 back-to-back on both variants: one-cycle latency, no gaps.
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'(i); in_ctrl = 8'(i);
      #1;
      chk($sformatf("s%0d_in_ready0", i), in_ready0, 1'b1);
      chk($sformatf("s%0d_in_ready1", i), in_ready1, 1'b1);
      @(posedge clk);
      #1;
      chk($sformatf("s%0d_out_valid0", i), out_valid0, 1'b1);
      chk($sformatf("s%0d_out_data0", i), out_data0, 32'(i));
      chk($sformatf("s%0d_out_valid1", i), out_valid1, 1'b1);
      chk($sformatf("s%0d_out_data1", i), out_data1, 32'(i));
      chk($sformatf("s%0d_out_ctrl1", i), out_ctrl1, 8'(i));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("s_end_out_valid0", out_valid0, 1'b0);
    chk("s_end_out_valid1", out_valid1, 1'b0);
    chk("s_end_out_ctrl0", out_ctrl0, 8'h00);

    // Random traffic against FIFO scoreboards; both stages start empty here.
    seq = 32'h1000;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst = 1'b0;
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush = ($urandom_range(15) == 0);
      in_data = seq;
      seq = seq + 1;
      in_ctrl = 8'($urandom);
      #1;
      e_ir1 = (q1.size() < 2);
      e_ir0 = (q0.size() == 0) || out_ready;
      chk("r1_in_ready", in_ready1, e_ir1);
      chk("r1_out_valid", out_valid1, q1.size() != 0);
      if (q1.size() != 0) begin
        chk("r1_out_data", out_data1, q1[0].d);
        chk("r1_out_ctrl", out_ctrl1, q1[0].c);
      end else begin
        chk("r1_bubble_ctrl", out_ctrl1, 8'h00);
      end
      chk("r0_in_ready", in_ready0, e_ir0);
      chk("r0_out_valid", out_valid0, q0.size() != 0);
      if (q0.size() != 0) begin
        chk("r0_out_data", out_data0, q0[0].d);
        chk("r0_out_ctrl", out_ctrl0, q0[0].c);
      end else begin
        chk("r0_bubble_ctrl", out_ctrl0, 8'h00);
      end
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (q1.size() != 0 && out_ready) void'(q1.pop_front());
        if (in_valid && e_ir1) q1.push_back('{in_data, in_ctrl});
        if (q0.size() != 0 && out_ready) void'(q0.pop_front());
        if (in_valid && e_ir0) q0.push_back('{in_data, in_ctrl});
      end
      @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
